// File: rtl/param_loader.sv
// param_loader: decodes framed command bytes into single-cycle parameter-table writes.
// Frame: 0xA5, ADDR {id, idx}, DHI, DLO, and with PARAM_CHECKSUM_EN defined a
// trailing CSUM = ADDR ^ DHI ^ DLO. Without the macro the frame ends at DLO.
// A stalled frame is abandoned after TIMEOUT idle cycles with error code 3.
module param_loader #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_wr_en,
    output logic [3:0]  o_wr_id,
    output logic [3:0]  o_wr_idx,
    output logic [15:0] o_wr_data,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_frame_cnt
);

    localparam logic [7:0] HDR    = 8'hA5;
    localparam logic [3:0] MAX_ID = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DHI    = 3'd2,
        S_DLO    = 3'd3,
`ifdef PARAM_CHECKSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_COMMIT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, dhi_q;
`ifdef PARAM_CHECKSUM_EN
    logic [7:0]  dlo_q;
`endif
    logic [15:0] idle_cnt_q;
    logic        accept, in_frame, timeout, last_byte;
    logic        csum_bad, id_bad, commit_ok, commit_err;
    logic [15:0] frame_data;

    // COMMIT is the only cycle that refuses input
    assign o_ready  = (state_q != S_COMMIT);
    assign accept   = i_valid && o_ready;
    assign in_frame = (state_q != S_IDLE) && (state_q != S_COMMIT);
    // An accepted byte always beats the timeout on the same cycle
    assign timeout  = in_frame && !accept && (idle_cnt_q == TIMEOUT);
    assign id_bad   = (addr_q[7:4] > MAX_ID);

`ifdef PARAM_CHECKSUM_EN
    assign last_byte  = accept && (state_q == S_CSUM);
    assign csum_bad   = (i_data != (addr_q ^ dhi_q ^ dlo_q));
    assign frame_data = {dhi_q, dlo_q};
`else
    assign last_byte  = accept && (state_q == S_DLO);
    assign csum_bad   = 1'b0;
    assign frame_data = {dhi_q, i_data};
`endif

    assign commit_ok  = last_byte && !csum_bad && !id_bad;
    assign commit_err = last_byte && (csum_bad || id_bad);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: one step per accepted byte, timeout falls back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && (i_data == HDR)) state_d = S_ADDR;
            S_ADDR:   if (accept) state_d = S_DHI;
                      else if (timeout) state_d = S_IDLE;
            S_DHI:    if (accept) state_d = S_DLO;
                      else if (timeout) state_d = S_IDLE;
`ifdef PARAM_CHECKSUM_EN
            S_DLO:    if (accept) state_d = S_CSUM;
                      else if (timeout) state_d = S_IDLE;
            S_CSUM:   if (accept) state_d = S_COMMIT;
                      else if (timeout) state_d = S_IDLE;
`else
            S_DLO:    if (accept) state_d = S_COMMIT;
                      else if (timeout) state_d = S_IDLE;
`endif
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Frame field capture; data path needs no reset
    always_ff @(posedge clk) begin
        if (accept && (state_q == S_ADDR)) addr_q <= i_data;
        if (accept && (state_q == S_DHI))  dhi_q  <= i_data;
`ifdef PARAM_CHECKSUM_EN
        if (accept && (state_q == S_DLO))  dlo_q  <= i_data;
`endif
    end

    // Idle counter: cleared in IDLE and on every accepted byte
    always_ff @(posedge clk) begin
        if (!rst_n)                           idle_cnt_q <= 16'd0;
        else if (state_q == S_IDLE || accept) idle_cnt_q <= 16'd0;
        else                                  idle_cnt_q <= idle_cnt_q + 16'd1;
    end

    // Outputs registered on the final byte so they are valid during COMMIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_wr_en     <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= 2'd0;
            o_wr_id     <= 4'd0;
            o_wr_idx    <= 4'd0;
            o_wr_data   <= 16'd0;
            o_frame_cnt <= 16'd0;
        end else begin
            o_wr_en <= commit_ok;
            o_err   <= commit_err || timeout;
            if (commit_ok) begin
                o_wr_id     <= addr_q[7:4];
                o_wr_idx    <= addr_q[3:0];
                o_wr_data   <= frame_data;
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
            if (timeout)         o_err_code <= 2'd3;
            else if (commit_err) o_err_code <= csum_bad ? 2'd1 : 2'd2;
        end
    end

endmodule

// File: tb/tb_param_loader.sv
// tb_param_loader: directed frame table plus randomized byte streams, all outputs
// compared every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_param_loader;

    localparam logic [15:0] TMO = 16'd1000;
`ifdef PARAM_CHECKSUM_EN
    localparam int FLEN  = 5;
    localparam bit CS_EN = 1'b1;
`else
    localparam int FLEN  = 4;
    localparam bit CS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_data = 8'd0;
    logic        i_valid = 1'b0;
    logic        o_ready, o_wr_en, o_err;
    logic [3:0]  o_wr_id, o_wr_idx;
    logic [15:0] o_wr_data, o_frame_cnt;
    logic [1:0]  o_err_code;

    always #5 clk = ~clk;

    param_loader #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_wr_en(o_wr_en), .o_wr_id(o_wr_id),
        .o_wr_idx(o_wr_idx), .o_wr_data(o_wr_data), .o_err(o_err),
        .o_err_code(o_err_code), .o_frame_cnt(o_frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects accepted bytes of the current frame and judges it whole
    logic [7:0]  mq[$];
    bit          m_commit = 1'b0;
    bit          m_live = 1'b0;
    int          m_idle = 0;
    logic        m_wr_en, m_err, m_acc;
    logic [1:0]  m_code;
    logic [3:0]  m_id, m_idx;
    logic [15:0] m_data, m_cnt;
    logic [7:0]  ma, mh, ml;

    always @(posedge clk) begin
        m_live = 1'b1;
        m_acc  = i_valid && !m_commit;
        if (!rst_n) begin
            mq.delete();
            m_commit = 1'b0; m_idle = 0;
            m_wr_en = 1'b0; m_err = 1'b0; m_code = 2'd0;
            m_id = 4'd0; m_idx = 4'd0; m_data = 16'd0; m_cnt = 16'd0;
        end else begin
            m_wr_en = 1'b0;
            m_err   = 1'b0;
            if (m_commit) begin
                m_commit = 1'b0;
            end else if (mq.size() == 0) begin
                if (m_acc && i_data == 8'hA5) begin
                    mq.push_back(i_data);
                    m_idle = 0;
                end
            end else if (m_acc) begin
                mq.push_back(i_data);
                m_idle = 0;
                if (mq.size() == FLEN) begin
                    ma = mq[1]; mh = mq[2]; ml = mq[3];
                    if (CS_EN && (mq[FLEN-1] != (ma ^ mh ^ ml))) begin
                        m_err = 1'b1; m_code = 2'd1;
                    end else if (ma[7:4] > 4'd8) begin
                        m_err = 1'b1; m_code = 2'd2;
                    end else begin
                        m_wr_en = 1'b1;
                        m_id = ma[7:4]; m_idx = ma[3:0]; m_data = {mh, ml};
                        m_cnt = m_cnt + 16'd1;
                    end
                    mq.delete();
                    m_commit = 1'b1;
                end
            end else if (m_idle == int'(TMO)) begin
                m_err = 1'b1; m_code = 2'd3;
                mq.delete();
            end else begin
                m_idle++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model on the inactive edge
    always @(negedge clk) begin
        if (m_live) begin
            chk("ready",     32'(o_ready),     32'(!m_commit));
            chk("wr_en",     32'(o_wr_en),     32'(m_wr_en));
            chk("err",       32'(o_err),       32'(m_err));
            chk("err_code",  32'(o_err_code),  32'(m_code));
            chk("wr_id",     32'(o_wr_id),     32'(m_id));
            chk("wr_idx",    32'(o_wr_idx),    32'(m_idx));
            chk("wr_data",   32'(o_wr_data),   32'(m_data));
            chk("frame_cnt", 32'(o_frame_cnt), 32'(m_cnt));
        end
    end

    typedef struct {
        logic [39:0] b;        // first byte in [39:32]
        logic [1:0]  code_cs;  // expected code with checksum, 0 = write
        logic [1:0]  code_nc;  // expected code without checksum
        logic [3:0]  id;
        logic [3:0]  idx;
        logic [15:0] data;
    } vec_t;

    vec_t        tbl [8];
    logic [15:0] tb_cnt = 16'd0;

    task automatic send_byte(input logic [7:0] d);
        int   n = 0;
        logic rdy;
        i_data  = d;
        i_valid = 1'b1;
        do begin
            rdy = o_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 20);
        chk("byte_accepted", 32'(rdy), 32'(1));
        i_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int gap_at, input int gap_len);
        logic [1:0] ec;
        for (int k = 0; k < FLEN; k++) begin
            if (k == gap_at) repeat (gap_len) begin @(posedge clk); #1; end
            send_byte(v.b[39-8*k -: 8]);
            if (k < FLEN-1) chk({tag, "_no_err_mid"}, 32'(o_err), 32'(0));
        end
        ec = CS_EN ? v.code_cs : v.code_nc;
        chk({tag, "_ready"}, 32'(o_ready), 32'(0));
        chk({tag, "_wr_en"}, 32'(o_wr_en), 32'(ec == 2'd0));
        chk({tag, "_err"},   32'(o_err),   32'(ec != 2'd0));
        if (ec == 2'd0) begin
            tb_cnt = tb_cnt + 16'd1;
            chk({tag, "_id"},   32'(o_wr_id),   32'(v.id));
            chk({tag, "_idx"},  32'(o_wr_idx),  32'(v.idx));
            chk({tag, "_data"}, 32'(o_wr_data), 32'(v.data));
        end else begin
            chk({tag, "_code"}, 32'(o_err_code), 32'(ec));
        end
        chk({tag, "_cnt"}, 32'(o_frame_cnt), 32'(tb_cnt));
        @(posedge clk); #1;
        chk({tag, "_strobe_end"}, 32'({o_wr_en, o_err}), 32'(0));
        chk({tag, "_ready_back"}, 32'(o_ready), 32'(1));
    endtask

    initial begin
        int n;
        logic [7:0] a, h, l, c;
        logic [7:0] fr[$];

        tbl[0] = '{40'hA5_25_00_64_41, 2'd0, 2'd0, 4'd2, 4'd5,  16'h0064};
        tbl[1] = '{40'hA5_25_00_64_40, 2'd1, 2'd0, 4'd2, 4'd5,  16'h0064};
        tbl[2] = '{40'hA5_9F_12_34_B9, 2'd2, 2'd2, 4'd0, 4'd0,  16'h0000};
        tbl[3] = '{40'hA5_03_23_28_08, 2'd0, 2'd0, 4'd0, 4'd3,  16'd9000};
        tbl[4] = '{40'hA5_2F_00_14_3B, 2'd0, 2'd0, 4'd2, 4'd15, 16'd20};
        tbl[5] = '{40'hA5_8F_FF_FF_8F, 2'd0, 2'd0, 4'd8, 4'd15, 16'hFFFF};
        tbl[6] = '{40'hA5_F0_AB_CD_97, 2'd1, 2'd2, 4'd0, 4'd0,  16'h0000};
        tbl[7] = '{40'hA5_90_00_00_90, 2'd2, 2'd2, 4'd0, 4'd0,  16'h0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(o_ready), 32'(1));
        chk("rst_strobes", 32'({o_wr_en, o_err, o_err_code}), 32'(0));
        chk("rst_wr", 32'({o_wr_id, o_wr_idx, o_wr_data}), 32'(0));
        chk("rst_cnt", 32'(o_frame_cnt), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of single frames
        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i), -1, 0);

        // Timeout after the ADDR byte, then a good frame
        send_byte(8'hA5);
        send_byte(8'h03);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_err && n < 1200);
        chk("tmo_cycles", 32'(n), 32'(int'(TMO) + 1));
        chk("tmo_code", 32'(o_err_code), 32'(3));
        chk("tmo_no_write", 32'(o_wr_en), 32'(0));
        chk("tmo_cnt", 32'(o_frame_cnt), 32'(tb_cnt));
        @(posedge clk); #1;
        run_vec(tbl[3], "after_tmo", -1, 0);

        // Leading junk is discarded
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h11);
        run_vec(tbl[4], "junk", -1, 0);

        // Byte arriving exactly when the idle counter hits TIMEOUT is consumed
        run_vec(tbl[4], "byte_wins", 2, int'(TMO));

        // Reset mid-frame discards the partial frame
        send_byte(8'hA5);
        send_byte(8'h25);
        send_byte(8'h00);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_ready", 32'(o_ready), 32'(1));
        chk("mid_rst_strobes", 32'({o_wr_en, o_err, o_err_code}), 32'(0));
        chk("mid_rst_wr", 32'({o_wr_id, o_wr_idx, o_wr_data}), 32'(0));
        chk("mid_rst_cnt", 32'(o_frame_cnt), 32'(0));
        tb_cnt = 16'd0;
        run_vec(tbl[0], "post_rst", -1, 0);

        // Randomized streams of frames, junk, corrupted checksums and long gaps
        repeat (150) begin
            fr.delete();
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 3)) fr.push_back(8'($urandom));
            end else begin
                a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
                c = a ^ h ^ l;
                if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
                fr.push_back(8'hA5); fr.push_back(a); fr.push_back(h); fr.push_back(l);
                fr.push_back(c);
            end
            foreach (fr[k]) begin
                if ($urandom_range(0, 63) == 0) n = $urandom_range(int'(TMO) - 1, int'(TMO) + 1);
                else                            n = $urandom_range(0, 2);
                repeat (n) begin
                    i_data = 8'($urandom);
                    @(posedge clk); #1;
                end
                send_byte(fr[k]);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
